// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: shares one burst RAM between two cache ports.
// Arbitrates and forwards the command plus the 4-beat write burst.
// Read beats go back to the owner, and the minimum spacing between
// RAM commands is enforced.
// Optional macro BURST_RAM_ARBITER_FIXED_PRIORITY_EN: when defined,
// m0 wins every tie and m1 can starve. Default is round-robin.
// Ports:
//   m0_*/m1_* : requester command, write-data and read-return ports.
//   br_*      : burst RAM controller command and data interface.
module burst_ram_arbiter #(
  parameter int BURST_RAM_DEPTH_BITWIDTH = 21,
  parameter int BURST_BEATS              = 4,
  parameter int COMMAND_DELAY_INTERVAL   = 13
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                m0_cmd,
  input  logic                                m0_cmd_en,
  output logic                                m0_cmd_ready,
  input  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] m0_addr,
  input  logic [63:0]                         m0_wr_data,
  input  logic [7:0]                          m0_data_mask,
  output logic [63:0]                         m0_rd_data,
  output logic                                m0_rd_data_valid,
  input  logic                                m1_cmd,
  input  logic                                m1_cmd_en,
  output logic                                m1_cmd_ready,
  input  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] m1_addr,
  input  logic [63:0]                         m1_wr_data,
  input  logic [7:0]                          m1_data_mask,
  output logic [63:0]                         m1_rd_data,
  output logic                                m1_rd_data_valid,
  output logic                                br_cmd,
  output logic                                br_cmd_en,
  output logic [BURST_RAM_DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]                         br_wr_data,
  output logic [7:0]                          br_data_mask,
  input  logic [63:0]                         br_rd_data,
  input  logic                                br_rd_data_valid
);

  localparam int AW = BURST_RAM_DEPTH_BITWIDTH;
  localparam logic [1:0] LAST_BEAT = 2'(BURST_BEATS - 1);
  localparam logic [5:0] DLY       = 6'(COMMAND_DELAY_INTERVAL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_M0,
    OWN_M1
  } own_t;

  state_t          state_q, state_d;
  own_t            owner_q, owner_d;
  own_t            last_q, last_d;
  own_t            grant;
  own_t            tie;
  logic [1:0]      beat_q, beat_d;
  logic [5:0]      dly_q, dly_d;
  logic            cmd_q, cmd_d;
  logic            cmd_en_q, cmd_en_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [7:0]      mask_q, mask_d;
  logic            can_acc;
  logic            acc0, acc1;
  logic            vld0, vld1;

`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
  assign tie = OWN_M0;
`else
  assign tie = (last_q == OWN_M0) ? OWN_M1 : OWN_M0;
`endif

  always_comb begin
    grant = OWN_NONE;
    unique case ({m1_cmd_en, m0_cmd_en})
      2'b01:   grant = OWN_M0;
      2'b10:   grant = OWN_M1;
      2'b11:   grant = tie;
      default: grant = OWN_NONE;
    endcase
  end

  assign can_acc = !rst && (state_q == S_IDLE) && (dly_q == 6'd0);
  assign m0_cmd_ready = can_acc && (grant == OWN_M0);
  assign m1_cmd_ready = can_acc && (grant == OWN_M1);
  assign acc0 = m0_cmd_ready && m0_cmd_en;
  assign acc1 = m1_cmd_ready && m1_cmd_en;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    beat_d   = beat_q;
    dly_d    = (dly_q != 6'd0) ? dly_q - 6'd1 : dly_q;
    cmd_en_d = 1'b0;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    vld0     = 1'b0;
    vld1     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (acc0 || acc1) begin
          owner_d  = acc0 ? OWN_M0 : OWN_M1;
          last_d   = owner_d;
          cmd_en_d = 1'b1;
          // Loading here makes the counter read DLY in the pulse cycle.
          dly_d    = DLY;
          cmd_d    = acc0 ? m0_cmd : m1_cmd;
          addr_d   = acc0 ? m0_addr : m1_addr;
          wdata_d  = acc0 ? m0_wr_data : m1_wr_data;
          mask_d   = acc0 ? m0_data_mask : m1_data_mask;
          if (cmd_d) begin
            state_d = S_WRITE;
            beat_d  = 2'd1;
          end else begin
            state_d = S_READ;
            beat_d  = 2'd0;
          end
        end
      end
      S_WRITE: begin
        wdata_d = (owner_q == OWN_M1) ? m1_wr_data : m0_wr_data;
        if (beat_q == LAST_BEAT) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
          beat_d  = 2'd0;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      S_READ: begin
        if (br_rd_data_valid) begin
          vld0 = (owner_q == OWN_M0);
          vld1 = (owner_q == OWN_M1);
          if (beat_q == LAST_BEAT) begin
            state_d = S_IDLE;
            owner_d = OWN_NONE;
            beat_d  = 2'd0;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_NONE;
      last_q   <= OWN_M1;
      beat_q   <= 2'd0;
      dly_q    <= 6'd0;
      cmd_en_q <= 1'b0;
      cmd_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 64'd0;
      mask_q   <= 8'hFF;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      beat_q   <= beat_d;
      dly_q    <= dly_d;
      cmd_en_q <= cmd_en_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
    end
  end

  assign br_cmd_en    = cmd_en_q;
  assign br_cmd       = cmd_q;
  assign br_addr      = addr_q;
  assign br_wr_data   = wdata_q;
  assign br_data_mask = mask_q;

  assign m0_rd_data       = br_rd_data;
  assign m1_rd_data       = br_rd_data;
  assign m0_rd_data_valid = vld0 && !rst;
  assign m1_rd_data_valid = vld1 && !rst;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb_burst_ram_arbiter: directed vector bench for burst_ram_arbiter.
// Transaction table plus hand sequences for reset and stray beats.
module tb_burst_ram_arbiter;

  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cmd, m0_cmd_en, m0_cmd_ready;
  logic [AW-1:0] m0_addr;
  logic [63:0]   m0_wr_data, m0_rd_data;
  logic [7:0]    m0_data_mask;
  logic          m0_rd_data_valid;
  logic          m1_cmd, m1_cmd_en, m1_cmd_ready;
  logic [AW-1:0] m1_addr;
  logic [63:0]   m1_wr_data, m1_rd_data;
  logic [7:0]    m1_data_mask;
  logic          m1_rd_data_valid;
  logic          br_cmd, br_cmd_en;
  logic [AW-1:0] br_addr;
  logic [63:0]   br_wr_data, br_rd_data;
  logic [7:0]    br_data_mask;
  logic          br_rd_data_valid;

  burst_ram_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .m0_cmd           (m0_cmd),
    .m0_cmd_en        (m0_cmd_en),
    .m0_cmd_ready     (m0_cmd_ready),
    .m0_addr          (m0_addr),
    .m0_wr_data       (m0_wr_data),
    .m0_data_mask     (m0_data_mask),
    .m0_rd_data       (m0_rd_data),
    .m0_rd_data_valid (m0_rd_data_valid),
    .m1_cmd           (m1_cmd),
    .m1_cmd_en        (m1_cmd_en),
    .m1_cmd_ready     (m1_cmd_ready),
    .m1_addr          (m1_addr),
    .m1_wr_data       (m1_wr_data),
    .m1_data_mask     (m1_data_mask),
    .m1_rd_data       (m1_rd_data),
    .m1_rd_data_valid (m1_rd_data_valid),
    .br_cmd           (br_cmd),
    .br_cmd_en        (br_cmd_en),
    .br_addr          (br_addr),
    .br_wr_data       (br_wr_data),
    .br_data_mask     (br_data_mask),
    .br_rd_data       (br_rd_data),
    .br_rd_data_valid (br_rd_data_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          m0_en;
    logic          m0_cmd;
    logic [AW-1:0] m0_addr;
    logic          m1_en;
    logic          m1_cmd;
    logic [AW-1:0] m1_addr;
    int            exp_port;
    bit            chk_gap;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  int   last_acc = 0;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] wbeat(input int p, input int k);
    return ((p == 1) ? 64'hA0 : 64'hB0) + 64'(k);
  endfunction

  task automatic run_vec(input vec_t v, output int waited);
    int            port;
    int            acc;
    logic          ec;
    logic [AW-1:0] ea;
    logic [63:0]   bt;
    m0_cmd_en  = v.m0_en;
    m0_cmd     = v.m0_cmd;
    m0_addr    = v.m0_addr;
    m0_wr_data = wbeat(0, 0);
    m1_cmd_en  = v.m1_en;
    m1_cmd     = v.m1_cmd;
    m1_addr    = v.m1_addr;
    m1_wr_data = wbeat(1, 0);
    port   = -1;
    waited = 0;
    acc    = 0;
    while (port < 0 && waited < 40) begin
      @(negedge clk);
      if (m0_cmd_en && m0_cmd_ready) port = 0;
      else if (m1_cmd_en && m1_cmd_ready) port = 1;
      acc = cyc;
      @(posedge clk); #1;
      if (port < 0) waited++;
    end
    chk("grant", 64'(port), 64'(v.exp_port));
    if (port < 0) begin
      m0_cmd_en = 1'b0;
      m1_cmd_en = 1'b0;
      return;
    end
    if (v.chk_gap) chk("gap", 64'(acc - last_acc), 64'd14);
    last_acc = acc;
    ec = (port == 1) ? v.m1_cmd : v.m0_cmd;
    ea = (port == 1) ? v.m1_addr : v.m0_addr;
    if (port == 0) begin
      m0_cmd_en  = 1'b0;
      m0_wr_data = wbeat(0, 1);
    end else begin
      m1_cmd_en  = 1'b0;
      m1_wr_data = wbeat(1, 1);
    end
    @(negedge clk);
    chk("cmd_en", 64'(br_cmd_en), 64'd1);
    chk("cmd", 64'(br_cmd), 64'(ec));
    chk("addr", 64'(br_addr), 64'(ea));
    chk("mask", 64'(br_data_mask),
        (port == 1) ? 64'h0F : 64'hF0);
    if (ec) begin
      chk("wbeat0", br_wr_data, wbeat(port, 0));
      for (int k = 1; k <= 3; k++) begin
        @(posedge clk); #1;
        if (k < 3) begin
          if (port == 0) m0_wr_data = wbeat(0, k + 1);
          else m1_wr_data = wbeat(1, k + 1);
        end
        @(negedge clk);
        if (k == 1) chk("pulse", 64'(br_cmd_en), 64'd0);
        chk("wbeat", br_wr_data, wbeat(port, k));
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        bt = 64'h11 * 64'(k + 1);
        br_rd_data_valid = 1'b1;
        br_rd_data = bt;
        @(negedge clk);
        if (k == 0) chk("pulse", 64'(br_cmd_en), 64'd0);
        chk("own_vld", 64'(port == 1 ? m1_rd_data_valid
                                     : m0_rd_data_valid), 64'd1);
        chk("oth_vld", 64'(port == 1 ? m0_rd_data_valid
                                     : m1_rd_data_valid), 64'd0);
        chk("rdata", (port == 1) ? m1_rd_data : m0_rd_data, bt);
      end
    end
    @(posedge clk); #1;
    br_rd_data_valid = 1'b0;
  endtask

  initial begin
    int   w;
    logic got;
    vec_t v;
    rst              = 1'b1;
    m0_cmd           = 1'b0;
    m0_cmd_en        = 1'b0;
    m0_addr          = '0;
    m0_wr_data       = 64'd0;
    m0_data_mask     = 8'hF0;
    m1_cmd           = 1'b0;
    m1_cmd_en        = 1'b0;
    m1_addr          = '0;
    m1_wr_data       = 64'd0;
    m1_data_mask     = 8'h0F;
    br_rd_data       = 64'd0;
    br_rd_data_valid = 1'b0;

    tbl[0] = '{1'b1, 1'b0, 21'h000100, 1'b1, 1'b1, 21'h000040, 0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 21'h000100, 1'b1, 1'b1, 21'h000040, 1, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 21'h000200, 1'b1, 1'b0, 21'h000300, 0, 1'b1};
`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
    tbl[3] = '{1'b1, 1'b0, 21'h000210, 1'b1, 1'b0, 21'h000300, 0, 1'b1};
`else
    tbl[3] = '{1'b1, 1'b0, 21'h000210, 1'b1, 1'b0, 21'h000300, 1, 1'b1};
`endif
    tbl[4] = '{1'b1, 1'b0, 21'h000220, 1'b1, 1'b0, 21'h000300, 0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 21'h000220, 1'b1, 1'b0, 21'h000300, 1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    m0_cmd_en        = 1'b1;
    m1_cmd_en        = 1'b1;
    br_rd_data_valid = 1'b1;
    @(negedge clk);
    chk("rst_rdy0", 64'(m0_cmd_ready), 64'd0);
    chk("rst_rdy1", 64'(m1_cmd_ready), 64'd0);
    chk("rst_cmd_en", 64'(br_cmd_en), 64'd0);
    chk("rst_cmd", 64'(br_cmd), 64'd0);
    chk("rst_addr", 64'(br_addr), 64'd0);
    chk("rst_wdata", br_wr_data, 64'd0);
    chk("rst_mask", 64'(br_data_mask), 64'hFF);
    chk("rst_vld0", 64'(m0_rd_data_valid), 64'd0);
    chk("rst_vld1", 64'(m1_rd_data_valid), 64'd0);
    @(posedge clk); #1;
    rst              = 1'b0;
    m0_cmd_en        = 1'b0;
    m1_cmd_en        = 1'b0;
    br_rd_data_valid = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(tbl[i], w);

    for (int i = 0; i < 3; i++) begin
      br_rd_data_valid = 1'b1;
      br_rd_data = 64'hDEAD;
      @(negedge clk);
      chk("stray0", 64'(m0_rd_data_valid), 64'd0);
      chk("stray1", 64'(m1_rd_data_valid), 64'd0);
      @(posedge clk); #1;
    end
    br_rd_data_valid = 1'b0;
    v = '{1'b1, 1'b0, 21'h000400, 1'b0, 1'b0, 21'h0, 0, 1'b0};
    run_vec(v, w);

    m0_cmd    = 1'b0;
    m0_addr   = 21'h000123;
    m0_cmd_en = 1'b1;
    got       = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = m0_cmd_ready;
      @(posedge clk); #1;
    end
    chk("mid_acc", 64'(got), 64'd1);
    m0_cmd_en = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      br_rd_data_valid = 1'b1;
      br_rd_data = 64'h11 * 64'(k + 1);
      @(negedge clk);
      chk("mid_vld", 64'(m0_rd_data_valid), 64'd1);
      @(posedge clk); #1;
    end
    br_rd_data_valid = 1'b0;
    rst        = 1'b1;
    m1_cmd     = 1'b1;
    m1_addr    = 21'h000055;
    m1_wr_data = wbeat(1, 0);
    m1_cmd_en  = 1'b1;
    @(negedge clk);
    chk("in_rst_rdy1", 64'(m1_cmd_ready), 64'd0);
    @(posedge clk); #1;
    rst              = 1'b0;
    m1_cmd_en        = 1'b0;
    br_rd_data_valid = 1'b1;
    br_rd_data       = 64'h33;
    @(negedge clk);
    chk("ab_cmd_en", 64'(br_cmd_en), 64'd0);
    chk("ab_cmd", 64'(br_cmd), 64'd0);
    chk("ab_addr", 64'(br_addr), 64'd0);
    chk("ab_wdata", br_wr_data, 64'd0);
    chk("ab_mask", 64'(br_data_mask), 64'hFF);
    chk("ab_vld0", 64'(m0_rd_data_valid), 64'd0);
    chk("ab_vld1", 64'(m1_rd_data_valid), 64'd0);
    @(posedge clk); #1;
    br_rd_data = 64'h44;
    @(negedge clk);
    chk("ab_vld0b", 64'(m0_rd_data_valid), 64'd0);
    chk("ab_vld1b", 64'(m1_rd_data_valid), 64'd0);
    @(posedge clk); #1;
    br_rd_data_valid = 1'b0;
    v = '{1'b0, 1'b0, 21'h0, 1'b1, 1'b1, 21'h000055, 1, 1'b0};
    run_vec(v, w);
    chk("ab_wait", 64'(w), 64'd0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
